line_window_fetch: RTL and testbench
====================================

# line_window_fetch

Upstream feeder for the chess-form judge. On a start request for a candidate point (row, col) and a player colour, the block reads the 15x15 board memory one cell per cycle. It builds the 9-cell own-stone vector A and the blocker vector B for each of the four line directions, with the candidate cell at index 4. It presents each window for one cycle to the combinational judge, which sits directly downstream.

## Interface
Parameters:
- N, 15, board side length; cell address = row*N + col.
- AW, 8, board read address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request pulse; accepted only while ready=1.
- row  in  4  candidate row, sampled at accept.
- col  in  4  candidate column, sampled at accept.
- player  in  1  0 = black (cell code 01), 1 = white (cell code 10); sampled at accept.
- ready  out  1  high in IDLE.
- busy  out  1  high from the first cycle after accept through the done cycle.
- rd_en  out  1  board read strobe.
- rd_addr  out  AW  board read address.
- rd_data  in  2  cell code; valid in the cycle after rd_en (1-cycle latency). 00 = empty, 01 = black, 10 = white, 11 = reserved.
- win_valid  out  1  one-cycle pulse per direction.
- win_dir  out  2  0 = horizontal (dr 0, dc +1), 1 = vertical (+1, 0), 2 = diagonal (+1, +1), 3 = anti-diagonal (+1, -1).
- win_a  out  9  own-stone vector; bit k is cell offset t = k-4.
- win_b  out  9  blocker vector, same indexing.
- done  out  1  one-cycle pulse at end of request.
- occ  out  1  valid with done; candidate cell already occupied.

## Operation
- States: IDLE, CHECK (only with macro), FETCH, EMIT_LAST, DONE.
- IDLE→FETCH (or CHECK) on start while ready. A start while busy is ignored and not queued.
- Each direction d occupies 8 slots, for k = 0..3 and 5..8. The cell is (row + t*dr, col + t*dc).
- An on-board cell issues rd_en=1 with its address.
- An off-board cell (coordinate <0 or ≥N) issues rd_en=0. Its slot still takes one cycle.
- Classification, captured the cycle after the slot:
  - Own colour → A=1, B=0.
  - Empty → A=0, B=0.
  - Opponent colour, reserved code 11, or off-board → A=0, B=1.
- Index 4 is fixed at A=1, B=0.
- The slot stream is continuous across directions, with no bubble between d and d+1.
- win_valid for direction d is asserted the cycle after its slot-8 capture. win_a, win_b and win_dir are held until the next win_valid.
- done pulses in the same cycle as the direction-3 win_valid. The FSM is in IDLE, with ready=1, on the next cycle.
- row or col ≥ N is accepted. All neighbours are then off-board, giving A=9'h010, B=9'h1EF for every direction.

## Timing
- Reset values: ready=1; all other outputs 0, including win_a, win_b and win_dir.
- Cycle 0 is the accept edge. OFS=0 without the macro, 2 with it.
- Slot j (0..7) of direction d is issued in cycle 1+OFS+8d+j.
- win_valid for direction d is asserted in cycle 10+OFS+8d. done is asserted in cycle 34+OFS.
- busy is high in cycles 1..34+OFS. Throughput is one request per 35+OFS cycles.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and all outputs take their reset values. No further win_valid or done pulses are issued.

## Configuration
- LWF_OCC_CHECK_EN defined:
  - CHECK reads the candidate cell in cycle 1.
  - If the cell is non-empty, done=1 and occ=1 in cycle 3. There is no win_valid and no further reads.
  - Otherwise FETCH starts with OFS=2.
- LWF_OCC_CHECK_EN undefined: no CHECK state, OFS=0, and occ is tied to 0.

## Test plan
- Empty board, (7,7), player 0 → four win_valid pulses at cycles 10/18/26/34, each with A=9'h010, B=9'h000. done at cycle 34.
- Empty board, (0,0) → dirs 0-2: A=9'h010, B=9'h00F. dir 3: B=9'h1EF. rd_en stays low in every off-board slot.
- Black at (7,3..6), (7,7), player 0 → dir 0: A=9'h01F, B=9'h000. White at (7,8) added → dir 0: B=9'h020.
- Reset at cycle 12 of a request → busy=0 and ready=1 at once. No win_valid or done follows. A new start produces the full sequence.
- start pulsed at cycle 5 of a busy request → ignored. Exactly 4 windows and 1 done are produced.
- Macro defined, candidate cell = 10 → done and occ at cycle 3, no windows. Candidate empty → windows at cycles 12/20/28/36.

Source files
------------

// File: rtl/line_window_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_window_fetch                                                          |
// | Reads the four 9-cell line windows around a candidate point, one board     |
// | cell per cycle, and presents own-stone/blocker vectors to the judge.       |
// | Optional macro: LWF_OCC_CHECK_EN (pre-check that the candidate is empty).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module line_window_fetch #(
  parameter int N  = 15,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    row,
  input  logic [3:0]    col,
  input  logic          player,
  output logic          ready,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [1:0]    rd_data,
  output logic          win_valid,
  output logic [1:0]    win_dir,
  output logic [8:0]    win_a,
  output logic [8:0]    win_b,
  output logic          done,
  output logic          occ
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_FETCH     = 3'd2,
    S_EMIT_LAST = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  slot_q, slot_d;
  logic [3:0]  row_q, col_q;
  logic        player_q;
  logic        pend_q, pend_off_q;
  logic [3:0]  pend_k_q;
  logic [1:0]  pend_dir_q;
  logic [8:0]  acc_a_q, acc_b_q;
  logic        win_valid_q;
  logic [1:0]  win_dir_q;
  logic [8:0]  win_a_q, win_b_q;

  logic              accept;
  logic [1:0]        cur_dir;
  logic [2:0]        cur_j;
  logic [3:0]        cur_k;
  logic signed [5:0] t, dr, dc, r, c;
  logic              on_board;
  logic [AW-1:0]     slot_addr;
  logic [1:0]        own_code;
  logic              cap_a, cap_b;

  assign accept = start && (state_q == S_IDLE);

  // Slot j of a direction maps to window index k, skipping the candidate at k=4.
  assign cur_dir = slot_q[4:3];
  assign cur_j   = slot_q[2:0];
  assign cur_k   = (cur_j < 3'd4) ? {1'b0, cur_j} : ({1'b0, cur_j} + 4'd1);
  assign t       = $signed({2'b00, cur_k}) - 6'sd4;
  assign dr      = (cur_dir == 2'd0) ? 6'sd0 : 6'sd1;

  always_comb begin
    dc = 6'sd1;
    case (cur_dir)
      2'd1:    dc = 6'sd0;
      2'd3:    dc = -6'sd1;
      default: dc = 6'sd1;
    endcase
  end

  assign r         = $signed({2'b00, row_q}) + t * dr;
  assign c         = $signed({2'b00, col_q}) + t * dc;
  assign on_board  = (int'(r) >= 0) && (int'(r) < N) && (int'(c) >= 0) && (int'(c) < N);
  assign slot_addr = AW'(int'(r) * N + int'(c));

`ifdef LWF_OCC_CHECK_EN
  logic          cand_on;
  logic [AW-1:0] cand_addr;
  logic          occ_q, occ_d;
  assign cand_on   = (int'(row_q) < N) && (int'(col_q) < N);
  assign cand_addr = AW'(int'(row_q) * N + int'(col_q));
  assign occ       = occ_q;
`else
  assign occ = 1'b0;
`endif

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_q == S_FETCH && on_board) begin
      rd_en   = 1'b1;
      rd_addr = slot_addr;
    end
`ifdef LWF_OCC_CHECK_EN
    else if (state_q == S_CHECK && slot_q == 5'd0 && cand_on) begin
      rd_en   = 1'b1;
      rd_addr = cand_addr;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
`ifdef LWF_OCC_CHECK_EN
    occ_d   = occ_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          slot_d = '0;
`ifdef LWF_OCC_CHECK_EN
          occ_d   = 1'b0;
          state_d = S_CHECK;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef LWF_OCC_CHECK_EN
      // Second CHECK cycle sees the candidate's read data.
      S_CHECK: begin
        if (slot_q == 5'd0) begin
          slot_d = 5'd1;
        end else if (cand_on && rd_data != 2'b00) begin
          occ_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          slot_d  = '0;
          state_d = S_FETCH;
        end
      end
`endif
      S_FETCH: begin
        slot_d = slot_q + 5'd1;
        if (slot_q == 5'd31) state_d = S_EMIT_LAST;
      end
      S_EMIT_LAST: state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
`ifdef LWF_OCC_CHECK_EN
      occ_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
`ifdef LWF_OCC_CHECK_EN
      occ_q   <= occ_d;
`endif
    end
  end

  // Off-board cells were never read, so the stale bus value is ignored for them.
  assign own_code = player_q ? 2'b10 : 2'b01;
  assign cap_a    = !pend_off_q && (rd_data == own_code);
  assign cap_b    = pend_off_q || ((rd_data != 2'b00) && (rd_data != own_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      player_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_off_q  <= 1'b0;
      pend_k_q    <= '0;
      pend_dir_q  <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      win_valid_q <= 1'b0;
      win_dir_q   <= '0;
      win_a_q     <= '0;
      win_b_q     <= '0;
    end else begin
      win_valid_q <= 1'b0;
      if (accept) begin
        row_q    <= row;
        col_q    <= col;
        player_q <= player;
      end
      pend_q     <= (state_q == S_FETCH);
      pend_off_q <= !on_board;
      pend_k_q   <= cur_k;
      pend_dir_q <= cur_dir;
      if (pend_q) begin
        if (pend_k_q == 4'd8) begin
          win_a_q     <= {cap_a, acc_a_q[7:5], 1'b1, acc_a_q[3:0]};
          win_b_q     <= {cap_b, acc_b_q[7:5], 1'b0, acc_b_q[3:0]};
          win_dir_q   <= pend_dir_q;
          win_valid_q <= 1'b1;
        end else begin
          acc_a_q[pend_k_q] <= cap_a;
          acc_b_q[pend_k_q] <= cap_b;
        end
      end
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign win_valid = win_valid_q;
  assign win_dir   = win_dir_q;
  assign win_a     = win_a_q;
  assign win_b     = win_b_q;

endmodule
`default_nettype wire

// File: tb/tb_line_window_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_line_window_fetch                                                       |
// | Scoreboard bench: a board model answers reads, a line-walk model predicts  |
// | windows/done, and a monitor compares whatever the DUT emits.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_line_window_fetch;
  localparam int N  = 15;
  localparam int AW = 8;
`ifdef LWF_OCC_CHECK_EN
  localparam int OFS = 2;
  localparam bit CHK = 1'b1;
`else
  localparam int OFS = 0;
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    row = '0;
  logic [3:0]    col = '0;
  logic          player = 1'b0;
  logic          ready, busy, rd_en, win_valid, done, occ;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data = '0;
  logic [1:0]    win_dir;
  logic [8:0]    win_a, win_b;

  logic [1:0] board [0:255];

  typedef struct {
    bit         is_done;
    int         dir;
    logic [8:0] a;
    logic [8:0] b;
    bit         occ;
    int         cyc;
    int         reads;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_fail = 0, cyc = 0, t_acc = 0, rd_cnt = 0;

  line_window_fetch #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .row(row), .col(col), .player(player),
    .ready(ready), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .win_valid(win_valid), .win_dir(win_dir), .win_a(win_a), .win_b(win_b),
    .done(done), .occ(occ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Unread cycles return noise so any use of non-read data shows up.
  always @(posedge clk) rd_data <= rd_en ? board[rd_addr] : 2'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int cell_at(input int r, input int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return -1;
    return int'(board[r * N + c]);
  endfunction

  task automatic push_expected(input int r0, input int c0, input bit pl);
    exp_t e;
    int own, reads, cand, dr, dc, v;
    own   = pl ? 2 : 1;
    reads = 0;
    cand  = cell_at(r0, c0);
    if (CHK) begin
      if (cand >= 0) reads++;
      if (cand > 0) begin
        e.is_done = 1; e.dir = 0; e.a = '0; e.b = '0; e.occ = 1; e.cyc = 3; e.reads = reads;
        sb.push_back(e);
        return;
      end
    end
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      e.is_done = 0; e.dir = d; e.occ = 0; e.reads = 0; e.cyc = 10 + OFS + 8 * d;
      for (int k = 0; k < 9; k++) begin
        v = cell_at(r0 + (k - 4) * dr, c0 + (k - 4) * dc);
        if (k == 4) begin
          e.a[k] = 1'b1; e.b[k] = 1'b0;
        end else begin
          if (v >= 0) reads++;
          e.a[k] = (v == own);
          e.b[k] = (v < 0) || (v != 0 && v != own);
        end
      end
      sb.push_back(e);
    end
    e.is_done = 1; e.dir = 0; e.a = '0; e.b = '0; e.occ = 0; e.cyc = 34 + OFS; e.reads = reads;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (rd_en) begin
        rd_cnt++;
        if (rd_addr >= 8'd225) chk("rd_addr_range", 32'(rd_addr), 0);
      end
      if (win_valid) begin
        if (sb.size() == 0) chk("win_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("win_is_window", 32'(e.is_done), 0);
          chk("win_dir", 32'(win_dir), e.dir);
          chk("win_a", 32'(win_a), 32'(e.a));
          chk("win_b", 32'(win_b), 32'(e.b));
          chk("win_cycle", cyc - t_acc, e.cyc);
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_is_done", 32'(e.is_done), 1);
          chk("done_occ", 32'(occ), 32'(e.occ));
          chk("done_cycle", cyc - t_acc, e.cyc);
          chk("done_reads", rd_cnt, e.reads);
        end
        rd_cnt = 0;
      end
    end
  end

  task automatic issue(input int r, input int c, input bit pl);
    int i;
    i = 0;
    while (!ready && i < 100) begin @(negedge clk); i++; end
    if (!ready) chk("ready_timeout", 0, 1);
    row = 4'(r); col = 4'(c); player = pl; start = 1'b1;
    t_acc = cyc; rd_cnt = 0;
    push_expected(r, c, pl);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    bit seen;
    i = 0; seen = 0;
    while (i < 80 && !seen) begin
      if (done) seen = 1;
      else begin @(negedge clk); i++; end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
    chk("ready_after_done", 32'(ready), 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 256; i++) board[i] = 2'b00;
  endtask

  initial begin
    clear_board();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_win", {21'b0, win_dir, win_a}, 0);
    chk("rst_win_b", 32'(win_b), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    issue(7, 7, 0);  wait_done();
    issue(0, 0, 0);  wait_done();
    for (int cc = 3; cc <= 7; cc++) board[7 * N + cc] = 2'b01;
    issue(7, 7, 0);  wait_done();
    board[7 * N + 8] = 2'b10;
    issue(7, 7, 0);  wait_done();
    clear_board();
    issue(15, 15, 1); wait_done();
    issue(14, 0, 1);  wait_done();

    // Start pulsed mid-request must not be queued.
    issue(7, 7, 0);
    repeat (4) @(negedge clk);
    chk("busy_at_5", 32'(busy), 1);
    row = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset in the middle of a request.
    board[6 * N + 6] = 2'b10;
    issue(7, 7, 1);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(ready), 1);
    chk("midrst_win_valid", 32'(win_valid), 0);
    chk("midrst_rd_en", 32'(rd_en), 0);
    chk("midrst_win_a", 32'(win_a), 0);
    sb.delete(); rd_cnt = 0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_rst", 32'(busy), 0);
    issue(7, 7, 1); wait_done();

    board[7 * N + 7] = 2'b10;
    issue(7, 7, 0); wait_done();
    board[7 * N + 7] = 2'b11;
    issue(7, 7, 1); wait_done();

    for (int n = 0; n < 20; n++) begin
      int rr, cc2, v;
      for (int i = 0; i < N * N; i++) begin
        v = $urandom_range(0, 9);
        board[i] = (v < 5) ? 2'b00 : (v < 7) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
      end
      rr  = $urandom_range(0, 15);
      cc2 = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1 && rr < N && cc2 < N) board[rr * N + cc2] = 2'b00;
      issue(rr, cc2, 1'($urandom_range(0, 1)));
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
